// File: rtl/ddr3_cmd_scheduler.sv
// DDR3 command scheduler: turns host read/write requests into one-cycle
// ACT/READ/WRITE/READ_AP/WRITE_AP/PRE/REF pulses, enforces tRCD/tRP/tRFC
// spacing, issues periodic refreshes and keeps at most one row open.
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   INIT_DONE             command FSM finished init/ZQ (sampled in WAIT_INIT only)
//   REQ_VALID/REQ_READY   host request handshake
//   REQ_WRITE, REQ_AP     request type and auto-precharge flag
//   REQ_BANK/ROW/COL      request address
//   ACT..REF              one-cycle command pulses
//   BA, A                 bank/address accompanying the current command
//   REF_PENDING           number of owed refreshes
module ddr3_cmd_scheduler #(
    parameter int unsigned T_RCD   = 5,
    parameter int unsigned T_RP    = 5,
    parameter int unsigned T_RFC   = 10,
    parameter int unsigned T_REFI  = 780,
    parameter int unsigned REF_MAX = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        INIT_DONE,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic        REQ_AP,
    input  logic [2:0]  REQ_BANK,
    input  logic [15:0] REQ_ROW,
    input  logic [9:0]  REQ_COL,
    output logic        ACT,
    output logic        READ,
    output logic        WRITE,
    output logic        READ_AP,
    output logic        WRITE_AP,
    output logic        PRE,
    output logic        REF,
    output logic [2:0]  BA,
    output logic [15:0] A,
    output logic [3:0]  REF_PENDING
);

    localparam int unsigned CW   = 16;
    localparam int unsigned BKW  = 3;
    localparam int unsigned ROWW = 16;
    localparam int unsigned COLW = 10;
    localparam int unsigned PW   = 4;

    typedef enum logic [3:0] {
        WAIT_INIT,
        IDLE,
        OPEN,
        ACT_ISSUE,
        ACT_WAIT,
        RW_ISSUE,
        PRE_ISSUE,
        PRE_WAIT,
        REF_ISSUE,
        REF_WAIT,
        AP_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
    logic [CW-1:0]     refi_cnt, refi_cnt_nxt;
    logic [PW-1:0]     pend_nxt;
    logic              miss_pending, miss_pending_nxt;

    logic              lat_write, lat_write_nxt;
    logic              lat_ap, lat_ap_nxt;
    logic [BKW-1:0]    lat_bank, lat_bank_nxt;
    logic [ROWW-1:0]   lat_row, lat_row_nxt;
    logic [COLW-1:0]   lat_col, lat_col_nxt;

    logic              open_valid;
    logic [BKW-1:0]    open_bank;
    logic [ROWW-1:0]   open_row;

    logic              accept, hit, refi_wrap, ref_done;
    logic              ready_nxt;
    logic              act_nxt, read_nxt, write_nxt, read_ap_nxt, write_ap_nxt;
    logic              pre_nxt, ref_nxt;
    logic [BKW-1:0]    ba_nxt;
    logic [ROWW-1:0]   a_nxt;

    // Request acceptance, row-hit detection and latched-request update
    always_comb begin
        accept        = REQ_VALID && REQ_READY;
        hit           = open_valid && (REQ_BANK == open_bank) && (REQ_ROW == open_row);
        lat_write_nxt = accept ? REQ_WRITE : lat_write;
        lat_ap_nxt    = accept ? REQ_AP    : lat_ap;
        lat_bank_nxt  = accept ? REQ_BANK  : lat_bank;
        lat_row_nxt   = accept ? REQ_ROW   : lat_row;
        lat_col_nxt   = accept ? REQ_COL   : lat_col;
    end

    // tREFI timer and owed-refresh count; a wrap coinciding with REF nets to 0
    always_comb begin
        refi_wrap    = (state != WAIT_INIT) && (refi_cnt == CW'(T_REFI - 1));
        ref_done     = (state == REF_ISSUE);
        refi_cnt_nxt = refi_cnt;
        pend_nxt     = REF_PENDING;
        if (state != WAIT_INIT) begin
            refi_cnt_nxt = refi_wrap ? '0 : refi_cnt + CW'(1);
        end
        if (refi_wrap && !ref_done) begin
            if (REF_PENDING != PW'(REF_MAX)) begin
                pend_nxt = REF_PENDING + PW'(1);
            end
        end else if (ref_done && !refi_wrap && (REF_PENDING != '0)) begin
            pend_nxt = REF_PENDING - PW'(1);
        end
    end

    // Next-state logic; wait_cnt holds the remaining wait cycles of *_WAIT states
    always_comb begin
        state_nxt        = state;
        wait_cnt_nxt     = wait_cnt;
        miss_pending_nxt = miss_pending;
        case (state)
            WAIT_INIT: begin
                if (INIT_DONE) state_nxt = IDLE;
            end
            IDLE: begin
                if (REF_PENDING != '0) state_nxt = REF_ISSUE;
                else if (accept)       state_nxt = ACT_ISSUE;
            end
            OPEN: begin
                if (REF_PENDING != '0) begin
                    state_nxt        = PRE_ISSUE;
                    miss_pending_nxt = 1'b0;
                end else if (accept) begin
                    if (hit) begin
                        state_nxt = RW_ISSUE;
                    end else begin
                        state_nxt        = PRE_ISSUE;
                        miss_pending_nxt = 1'b1;
                    end
                end
            end
            ACT_ISSUE: begin
                if (T_RCD <= 1) begin
                    state_nxt = RW_ISSUE;
                end else begin
                    state_nxt    = ACT_WAIT;
                    wait_cnt_nxt = CW'(T_RCD - 1);
                end
            end
            ACT_WAIT: begin
                if (wait_cnt <= CW'(1)) state_nxt = RW_ISSUE;
                else                    wait_cnt_nxt = wait_cnt - CW'(1);
            end
            RW_ISSUE: begin
                if (!lat_ap) begin
                    state_nxt = OPEN;
                end else if (T_RP <= 1) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt    = AP_WAIT;
                    wait_cnt_nxt = CW'(T_RP - 1);
                end
            end
            AP_WAIT: begin
                if (wait_cnt <= CW'(1)) state_nxt = IDLE;
                else                    wait_cnt_nxt = wait_cnt - CW'(1);
            end
            PRE_ISSUE: begin
                if (T_RP <= 1) begin
                    state_nxt        = miss_pending ? ACT_ISSUE : REF_ISSUE;
                    miss_pending_nxt = 1'b0;
                end else begin
                    state_nxt    = PRE_WAIT;
                    wait_cnt_nxt = CW'(T_RP - 1);
                end
            end
            PRE_WAIT: begin
                // A precharge for a row miss continues to the new ACT; otherwise it was for refresh
                if (wait_cnt <= CW'(1)) begin
                    state_nxt        = miss_pending ? ACT_ISSUE : REF_ISSUE;
                    miss_pending_nxt = 1'b0;
                end else begin
                    wait_cnt_nxt = wait_cnt - CW'(1);
                end
            end
            REF_ISSUE: begin
                if (T_RFC <= 1) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt    = REF_WAIT;
                    wait_cnt_nxt = CW'(T_RFC - 1);
                end
            end
            REF_WAIT: begin
                if (wait_cnt <= CW'(1)) state_nxt = IDLE;
                else                    wait_cnt_nxt = wait_cnt - CW'(1);
            end
            default: state_nxt = WAIT_INIT;
        endcase
    end

    // Moore outputs for the coming cycle, registered below so they align with the state
    always_comb begin
        ready_nxt    = ((state_nxt == IDLE) || (state_nxt == OPEN)) && (pend_nxt == '0);
        act_nxt      = (state_nxt == ACT_ISSUE);
        read_nxt     = (state_nxt == RW_ISSUE) && !lat_write_nxt && !lat_ap_nxt;
        write_nxt    = (state_nxt == RW_ISSUE) &&  lat_write_nxt && !lat_ap_nxt;
        read_ap_nxt  = (state_nxt == RW_ISSUE) && !lat_write_nxt &&  lat_ap_nxt;
        write_ap_nxt = (state_nxt == RW_ISSUE) &&  lat_write_nxt &&  lat_ap_nxt;
        pre_nxt      = (state_nxt == PRE_ISSUE);
        ref_nxt      = (state_nxt == REF_ISSUE);
        a_nxt        = '0;
        ba_nxt       = '0;
        case (state_nxt)
            ACT_ISSUE: begin
                a_nxt  = lat_row_nxt;
                ba_nxt = lat_bank_nxt;
            end
            RW_ISSUE: begin
                a_nxt  = {5'b0, lat_ap_nxt, lat_col_nxt};
                ba_nxt = lat_bank_nxt;
            end
            PRE_ISSUE: ba_nxt = open_bank;
            default: ;
        endcase
    end

    // State, counters, latched request, open-row tracking and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= WAIT_INIT;
            wait_cnt     <= '0;
            refi_cnt     <= '0;
            miss_pending <= 1'b0;
            lat_write    <= 1'b0;
            lat_ap       <= 1'b0;
            lat_bank     <= '0;
            lat_row      <= '0;
            lat_col      <= '0;
            open_valid   <= 1'b0;
            open_bank    <= '0;
            open_row     <= '0;
            REQ_READY    <= 1'b0;
            ACT          <= 1'b0;
            READ         <= 1'b0;
            WRITE        <= 1'b0;
            READ_AP      <= 1'b0;
            WRITE_AP     <= 1'b0;
            PRE          <= 1'b0;
            REF          <= 1'b0;
            BA           <= '0;
            A            <= '0;
            REF_PENDING  <= '0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            refi_cnt     <= refi_cnt_nxt;
            miss_pending <= miss_pending_nxt;
            lat_write    <= lat_write_nxt;
            lat_ap       <= lat_ap_nxt;
            lat_bank     <= lat_bank_nxt;
            lat_row      <= lat_row_nxt;
            lat_col      <= lat_col_nxt;
            if (state == ACT_ISSUE) begin
                open_valid <= 1'b1;
                open_bank  <= lat_bank;
                open_row   <= lat_row;
            end else if ((state == PRE_ISSUE) || ((state == RW_ISSUE) && lat_ap)) begin
                open_valid <= 1'b0;
            end
            REQ_READY    <= ready_nxt;
            ACT          <= act_nxt;
            READ         <= read_nxt;
            WRITE        <= write_nxt;
            READ_AP      <= read_ap_nxt;
            WRITE_AP     <= write_ap_nxt;
            PRE          <= pre_nxt;
            REF          <= ref_nxt;
            BA           <= ba_nxt;
            A            <= a_nxt;
            REF_PENDING  <= pend_nxt;
        end
    end

endmodule

// File: doc/ddr3_cmd_scheduler.md
Name: ddr3_cmd_scheduler

Overview:
- Sits between the host request port and the DDR3 command state machine.
- Turns host read/write requests into one-cycle command pulses: ACT, READ, WRITE, READ_AP, WRITE_AP, PRE, REF.
- Enforces tRCD, tRP and tRFC spacing and generates periodic refreshes from a tREFI timer.
- Uses a single-open-row policy: at most one bank/row is open at any time.

Parameters:
- T_RCD, 5: cycles from the ACT pulse to the READ/WRITE pulse.
- T_RP, 5: cycles from a PRE or *_AP pulse to the next ACT or REF pulse.
- T_RFC, 10: cycles from the REF pulse to the next command.
- T_REFI, 780: refresh interval in cycles.
- REF_MAX, 8: saturation limit of the postponed-refresh count.
- All T_* values are ≥1 and fit in 16 bits.

Ports:
- CLK, input, 1: clock; all state updates on posedge.
- RESET_N, input, 1: reset; asynchronous assert, active-low.
- INIT_DONE, input, 1: command FSM has finished initialization and ZQ calibration.
- REQ_VALID, input, 1: host request valid.
- REQ_READY, output, 1: scheduler can accept a request.
- REQ_WRITE, input, 1: 1 = write, 0 = read.
- REQ_AP, input, 1: auto-precharge after the access.
- REQ_BANK, input, 3: bank address.
- REQ_ROW, input, 16: row address.
- REQ_COL, input, 10: column address.
- ACT, READ, WRITE, READ_AP, WRITE_AP, PRE, REF, output, 1 each: command pulses to the command FSM.
- BA, output, 3: bank address for the current command.
- A, output, 16: address for the current command.
- REF_PENDING, output, 4: number of owed refreshes.

Behaviour:
- Reset (RESET_N=0, any time, including mid-sequence):
  - State returns to WAIT_INIT.
  - All command outputs, BA, A, REQ_READY and REF_PENDING go to 0.
  - Open-row valid flag, latched request and all counters are cleared.
  - No partial command may be emitted after reset.
- States: WAIT_INIT, IDLE, OPEN, ACT_ISSUE, ACT_WAIT, RW_ISSUE, PRE_ISSUE, PRE_WAIT, REF_ISSUE, REF_WAIT, AP_WAIT.
- INIT_DONE is sampled only in WAIT_INIT; when it is 1, the next state is IDLE. It is ignored after that.
- tREFI counter:
  - Counts 0..T_REFI-1 from the cycle after WAIT_INIT is left.
  - On each wrap, REF_PENDING increments, saturating at REF_MAX.
  - A wrap in the same cycle as a REF pulse gives a net change of 0.
- Command outputs:
  - Moore outputs, high for exactly one cycle: while the FSM is in the corresponding *_ISSUE state. At most one command is high per cycle.
  - ACT: A=row, BA=bank.
  - READ/WRITE/*_AP: A[9:0]=col, A[10]=REQ_AP, other bits 0; BA=bank.
  - PRE: A=0, BA=open bank.
  - REF and no command: A=0, BA=0.
- REQ_READY = 1 only when state is IDLE or OPEN and REF_PENDING=0.
  - A request is accepted on a posedge with VALID&READY; bank, row, col, write and AP are latched at that edge.
- Priority: a pending refresh beats a valid request in the same cycle; READY is already low.
- From IDLE:
  - Refresh pending → REF_ISSUE.
  - Else request accepted → ACT_ISSUE.
- From OPEN:
  - Refresh pending → PRE_ISSUE, then refresh.
  - Accepted hit (bank and row equal the open bank/row) → RW_ISSUE.
  - Accepted miss (bank or row differs) → PRE_ISSUE → PRE_WAIT → ACT_ISSUE.
- Timing, measured from pulse cycle c:
  - ACT at c → RW at c+T_RCD.
  - PRE at c → ACT/REF at c+T_RP.
  - REF at c → next state IDLE, with the next command no earlier than c+T_RFC.
- RW_ISSUE without AP → OPEN. With AP → row is closed, AP_WAIT for T_RP cycles from the pulse, then IDLE.
  - Consequence: back-to-back hits are accepted at most every 2 cycles.
- REF_ISSUE decrements REF_PENDING by 1. If the count is still nonzero after REF_WAIT, IDLE goes directly to REF_ISSUE again.
- REQ_* inputs may change freely when VALID&READY is 0; only latched values are used.

Test Plan:
- Reset release with INIT_DONE=1, request {rd, bank 2, row 0x0123, col 0x045, AP=0} accepted at edge N:
  - ACT with A=0x0123, BA=2 in cycle N.
  - READ with A=0x0045, BA=2 in cycle N+5.
  - State OPEN afterwards.
- Row hit: same bank/row write, col 0x010, accepted in OPEN:
  - WRITE pulse the next cycle, A=0x0010.
  - REQ_READY low for 1 cycle, then high again.
- Row miss to bank 2, row 0x0200:
  - PRE (BA=2, A=0), ACT 5 cycles later (A=0x0200), WRITE 5 cycles after the ACT.
- Auto-precharge read, col 0x3FF:
  - READ_AP with A=0x07FF.
  - REQ_READY low for 5 cycles, then state IDLE.
- Refresh while a row is open and REQ_VALID is held high:
  - After 780 cycles REF_PENDING=1 and REQ_READY=0.
  - PRE, then REF 5 cycles later, then no command for 10 cycles; REF_PENDING returns to 0.
- Assert RESET_N=0 during ACT_WAIT:
  - All outputs 0 immediately; no READ emitted.
  - After release with INIT_DONE=1 the FSM starts from IDLE with REF_PENDING=0.
